// File: rtl/sram_axi_bridge_if.sv
// Bus bundle between the core's SRAM-like fetch/data ports, the bridge and the AXI fabric.
// The master modport is the bridge's view; the slave modport is the core plus AXI slave side.
interface sram_axi_bridge_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/sram_axi_bridge.sv
// Merges the core's fetch and data SRAM-like ports onto one AXI master; one read in flight
// per port plus one write, responses steered back by ID.
//
// state  | meaning
// W_IDLE | no store in flight; data port may take a store or a load
// W_REQ  | awvalid/wvalid presented, each drops on its own handshake
// W_RESP | AW and W both done, waiting for bvalid
module sram_axi_bridge (
  input  logic clk,
  input  logic resetn,
  sram_axi_bridge_if.master bus
);
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_REQ  = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [1:0]  w_state;
  logic        ar_valid_q;
  logic        ar_id_q;
  logic [31:0] ar_addr_q;
  logic [1:0]  ar_size_q;
  logic        inst_rd_pend;
  logic        data_rd_pend;
  logic        aw_valid_q;
  logic        w_valid_q;
  logic [31:0] aw_addr_q;
  logic [1:0]  aw_size_q;
  logic [3:0]  w_strb_q;
  logic [31:0] w_data_q;

  logic w_idle;
  logic data_rd_ok;
  logic data_wr_ok;
  logic inst_rd_acc;
  logic data_rd_acc;
  logic data_wr_acc;
  logic rsp_inst;
  logic rsp_data;
  logic b_done;
  logic aw_done;
  logic w_done;

  assign w_idle     = (w_state == W_IDLE);
  // Holding loads until W_IDLE keeps a load from overtaking an older store to the same address.
  assign data_rd_ok = !ar_valid_q && !data_rd_pend && w_idle;
  assign data_wr_ok = w_idle && !data_rd_pend && !(ar_valid_q && ar_id_q);

  assign bus.data_sram_addr_ok = bus.data_sram_wr ? data_wr_ok : data_rd_ok;
  assign bus.inst_sram_addr_ok = !ar_valid_q && !inst_rd_pend &&
                                 !(bus.data_sram_req && !bus.data_sram_wr && data_rd_ok);

  assign data_rd_acc = bus.data_sram_req && !bus.data_sram_wr && data_rd_ok;
  assign data_wr_acc = bus.data_sram_req &&  bus.data_sram_wr && data_wr_ok;
  assign inst_rd_acc = bus.inst_sram_req && bus.inst_sram_addr_ok;

  assign rsp_inst = bus.rvalid && (bus.rid == 4'd0);
  assign rsp_data = bus.rvalid && (bus.rid == 4'd1);
  assign b_done   = bus.bvalid && (w_state == W_RESP);

  assign bus.inst_sram_data_ok = rsp_inst;
  assign bus.inst_sram_rdata   = bus.rdata;
  assign bus.data_sram_data_ok = rsp_data || b_done;
  assign bus.data_sram_rdata   = bus.rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_valid_q <= 1'b0;
      ar_id_q    <= 1'b0;
      ar_addr_q  <= 32'd0;
      ar_size_q  <= 2'd0;
    end else if (data_rd_acc || inst_rd_acc) begin
      ar_valid_q <= 1'b1;
      ar_id_q    <= data_rd_acc;
      ar_addr_q  <= data_rd_acc ? bus.data_sram_addr : bus.inst_sram_addr;
      ar_size_q  <= data_rd_acc ? bus.data_sram_size : bus.inst_sram_size;
    end else if (ar_valid_q && bus.arready) begin
      ar_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_rd_pend <= 1'b0;
      data_rd_pend <= 1'b0;
    end else begin
      if (inst_rd_acc)   inst_rd_pend <= 1'b1;
      else if (rsp_inst) inst_rd_pend <= 1'b0;
      if (data_rd_acc)   data_rd_pend <= 1'b1;
      else if (rsp_data) data_rd_pend <= 1'b0;
    end
  end

  assign aw_done = !aw_valid_q || bus.awready;
  assign w_done  = !w_valid_q  || bus.wready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state    <= W_IDLE;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      aw_addr_q  <= 32'd0;
      aw_size_q  <= 2'd0;
      w_strb_q   <= 4'd0;
      w_data_q   <= 32'd0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (data_wr_acc) begin
            aw_addr_q  <= bus.data_sram_addr;
            aw_size_q  <= bus.data_sram_size;
            w_strb_q   <= bus.data_sram_wstrb;
            w_data_q   <= bus.data_sram_wdata;
            aw_valid_q <= 1'b1;
            w_valid_q  <= 1'b1;
            w_state    <= W_REQ;
          end
        end
        W_REQ: begin
          if (aw_valid_q && bus.awready) aw_valid_q <= 1'b0;
          if (w_valid_q && bus.wready)   w_valid_q  <= 1'b0;
          if (aw_done && w_done)         w_state    <= W_RESP;
        end
        W_RESP: begin
          if (bus.bvalid) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign bus.arid    = {3'b000, ar_id_q};
  assign bus.araddr  = ar_addr_q;
  assign bus.arsize  = {1'b0, ar_size_q};
  assign bus.arvalid = ar_valid_q;
  assign bus.arlen   = 8'd0;
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'd0;
  assign bus.arprot  = 3'd0;
  assign bus.rready  = 1'b1;

  assign bus.awid    = 4'd1;
  assign bus.awaddr  = aw_addr_q;
  assign bus.awsize  = {1'b0, aw_size_q};
  assign bus.awvalid = aw_valid_q;
  assign bus.awlen   = 8'd0;
  assign bus.awburst = 2'b01;
  assign bus.awlock  = 2'b00;
  assign bus.awcache = 4'd0;
  assign bus.awprot  = 3'd0;

  assign bus.wid     = 4'd1;
  assign bus.wdata   = w_data_q;
  assign bus.wstrb   = w_strb_q;
  assign bus.wlast   = 1'b1;
  assign bus.wvalid  = w_valid_q;
  assign bus.bready  = 1'b1;

  logic unused_ok;
  assign unused_ok = ^{bus.inst_sram_wr, bus.inst_sram_wstrb, bus.inst_sram_wdata,
                       bus.rresp, bus.rlast, bus.bid, bus.bresp};
endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the bench plays core and AXI slave, expected responses
// are queued per port at request acceptance and compared when data_ok fires.
module tb_sram_axi_bridge;
  logic clk;
  logic resetn;
  int   n_vec;
  int   n_err;

  logic [31:0] inst_exp_q[$];
  logic [32:0] data_exp_q[$];

  sram_axi_bridge_if bus();

  sram_axi_bridge dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  // Response scoreboard: every data_ok must match the oldest queued expectation of its port.
  always @(negedge clk) begin
    if (resetn && bus.inst_sram_data_ok) begin
      if (inst_exp_q.size() == 0) chk("inst_unexpected_dok", 32'd1, 32'd0);
      else chk("inst_rdata", bus.inst_sram_rdata, inst_exp_q.pop_front());
    end
    if (resetn && bus.data_sram_data_ok) begin
      if (data_exp_q.size() == 0) chk("data_unexpected_dok", 32'd1, 32'd0);
      else begin
        logic [32:0] e;
        e = data_exp_q.pop_front();
        chk("data_kind", {31'd0, bus.bvalid}, {31'd0, e[32]});
        if (!e[32]) chk("data_rdata", bus.data_sram_rdata, e[31:0]);
      end
    end
    if (resetn && bus.rvalid && bus.rid == 4'd0) chk("rsp_inst_pend", {31'd0, dut.inst_rd_pend}, 32'd1);
    if (resetn && bus.rvalid && bus.rid == 4'd1) chk("rsp_data_pend", {31'd0, dut.data_rd_pend}, 32'd1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    n_vec = 0;
    n_err = 0;
    resetn = 1'b0;
    bus.inst_sram_req = 0; bus.inst_sram_wr = 0; bus.inst_sram_size = 0;
    bus.inst_sram_wstrb = 0; bus.inst_sram_addr = 0; bus.inst_sram_wdata = 0;
    bus.data_sram_req = 0; bus.data_sram_wr = 0; bus.data_sram_size = 0;
    bus.data_sram_wstrb = 0; bus.data_sram_addr = 0; bus.data_sram_wdata = 0;
    bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0; bus.rvalid = 0;
    bus.awready = 0; bus.wready = 0; bus.bid = 0; bus.bresp = 0; bus.bvalid = 0;

    repeat (2) @(posedge clk);
    smp();
    chk("rst_arvalid", {31'd0, bus.arvalid}, 32'd0);
    chk("rst_awvalid", {31'd0, bus.awvalid}, 32'd0);
    chk("rst_wvalid",  {31'd0, bus.wvalid}, 32'd0);
    chk("rst_araddr",  bus.araddr, 32'd0);
    chk("rst_consts",  {bus.rready, bus.bready, bus.wlast, bus.arburst, bus.awburst, bus.awid, bus.wid},
                       {1'b1, 1'b1, 1'b1, 2'b01, 2'b01, 4'd1, 4'd1});
    chk("rst_fixed0",  {bus.arlen, bus.arlock, bus.arcache, bus.arprot, bus.awlen, bus.arid},
                       32'd0);

    step(); resetn = 1'b1;

    // fetch
    bus.inst_sram_req = 1; bus.inst_sram_addr = 32'h1c000000; bus.inst_sram_size = 2;
    smp(); chk("fetch_aok", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
    inst_exp_q.push_back(32'h02800404);
    step(); bus.inst_sram_req = 0; bus.arready = 1;
    smp();
    chk("fetch_arvalid", {31'd0, bus.arvalid}, 32'd1);
    chk("fetch_arid", {28'd0, bus.arid}, 32'd0);
    chk("fetch_araddr", bus.araddr, 32'h1c000000);
    chk("fetch_arsize", {29'd0, bus.arsize}, 32'd2);
    step(); bus.arready = 0;
    smp(); chk("fetch_ar_drop", {31'd0, bus.arvalid}, 32'd0);
    step(); bus.rvalid = 1; bus.rid = 0; bus.rdata = 32'h02800404;
    smp(); chk("fetch_dok", {31'd0, bus.inst_sram_data_ok}, 32'd1);
    chk("fetch_no_data_dok", {31'd0, bus.data_sram_data_ok}, 32'd0);
    step(); bus.rvalid = 0;

    // back-to-back fetches with random addresses and data
    for (int i = 0; i < 4; i++) begin
      a = $urandom & 32'hffff_fffc;
      d = $urandom;
      bus.inst_sram_req = 1; bus.inst_sram_addr = a;
      smp(); chk("rnd_aok", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
      inst_exp_q.push_back(d);
      step(); bus.inst_sram_req = 0; bus.arready = 1;
      smp(); chk("rnd_araddr", bus.araddr, a);
      step(); bus.arready = 0; bus.rvalid = 1; bus.rid = 0; bus.rdata = d;
      smp();
      step(); bus.rvalid = 0;
    end

    // arbitration: data read wins, inst follows once AR frees, responses out of order
    bus.inst_sram_req = 1; bus.inst_sram_addr = 32'h1c000040; bus.inst_sram_size = 2;
    bus.data_sram_req = 1; bus.data_sram_wr = 0; bus.data_sram_addr = 32'h0000_2000; bus.data_sram_size = 2;
    smp();
    chk("arb_data_aok", {31'd0, bus.data_sram_addr_ok}, 32'd1);
    chk("arb_inst_blocked", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
    data_exp_q.push_back({1'b0, 32'haaaa_0002});
    step(); bus.data_sram_req = 0;
    smp();
    chk("arb_arid_data", {28'd0, bus.arid}, 32'd1);
    chk("arb_inst_wait", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
    step(); bus.arready = 1;
    smp(); chk("arb_inst_wait2", {31'd0, bus.inst_sram_addr_ok}, 32'd0);
    step();
    smp();
    chk("arb_ar_free", {31'd0, bus.arvalid}, 32'd0);
    chk("arb_inst_aok", {31'd0, bus.inst_sram_addr_ok}, 32'd1);
    inst_exp_q.push_back(32'hbbbb_0001);
    step(); bus.inst_sram_req = 0;
    smp();
    chk("arb_arid_inst", {28'd0, bus.arid}, 32'd0);
    chk("arb_araddr_inst", bus.araddr, 32'h1c000040);
    step(); bus.arready = 0; bus.rvalid = 1; bus.rid = 0; bus.rdata = 32'hbbbb_0001;
    smp(); chk("arb_rid0_not_data", {31'd0, bus.data_sram_data_ok}, 32'd0);
    step(); bus.rid = 1; bus.rdata = 32'haaaa_0002;
    smp(); chk("arb_rid1_not_inst", {31'd0, bus.inst_sram_data_ok}, 32'd0);
    step(); bus.rvalid = 0;

    // store with split AW/W handshake, then a load blocked until after bvalid
    bus.data_sram_req = 1; bus.data_sram_wr = 1; bus.data_sram_addr = 32'h100;
    bus.data_sram_size = 2; bus.data_sram_wstrb = 4'hf; bus.data_sram_wdata = 32'hdeadbeef;
    smp(); chk("st_aok", {31'd0, bus.data_sram_addr_ok}, 32'd1);
    data_exp_q.push_back({1'b1, 32'd0});
    step(); bus.data_sram_req = 0; bus.awready = 1;
    smp();
    chk("st_aw_w_valid", {30'd0, bus.awvalid, bus.wvalid}, 32'd3);
    chk("st_awaddr", bus.awaddr, 32'h100);
    chk("st_wdata", bus.wdata, 32'hdeadbeef);
    chk("st_wstrb", {28'd0, bus.wstrb}, 32'hf);
    step(); bus.awready = 0;
    smp(); chk("st_aw_done_w_held", {30'd0, bus.awvalid, bus.wvalid}, 32'd1);
    step(); bus.wready = 1;
    smp(); chk("st_w_at_t3", {31'd0, bus.wvalid}, 32'd1);
    step(); bus.wready = 0;
    bus.data_sram_req = 1; bus.data_sram_wr = 0; bus.data_sram_addr = 32'h100; bus.data_sram_size = 2;
    smp();
    chk("st_w_drop", {31'd0, bus.wvalid}, 32'd0);
    chk("raw_block_resp", {31'd0, bus.data_sram_addr_ok}, 32'd0);
    step(); bus.bvalid = 1;
    smp();
    chk("raw_block_b", {31'd0, bus.data_sram_addr_ok}, 32'd0);
    chk("st_dok", {31'd0, bus.data_sram_data_ok}, 32'd1);
    step(); bus.bvalid = 0;
    smp(); chk("raw_release", {31'd0, bus.data_sram_addr_ok}, 32'd1);
    data_exp_q.push_back({1'b0, 32'hdeadbeef});
    step(); bus.data_sram_req = 0; bus.arready = 1;
    smp(); chk("raw_araddr", bus.araddr, 32'h100);
    step(); bus.arready = 0; bus.rvalid = 1; bus.rid = 1; bus.rdata = 32'hdeadbeef;
    smp();
    step(); bus.rvalid = 0;

    // size mapping: byte load, halfword store
    bus.data_sram_req = 1; bus.data_sram_wr = 0; bus.data_sram_addr = 32'h203; bus.data_sram_size = 0;
    smp(); chk("byte_aok", {31'd0, bus.data_sram_addr_ok}, 32'd1);
    data_exp_q.push_back({1'b0, 32'h0000_0077});
    step(); bus.data_sram_req = 0; bus.arready = 1;
    smp(); chk("byte_arsize", {29'd0, bus.arsize}, 32'd0);
    step(); bus.arready = 0; bus.rvalid = 1; bus.rid = 1; bus.rdata = 32'h0000_0077;
    smp();
    step(); bus.rvalid = 0;
    bus.data_sram_req = 1; bus.data_sram_wr = 1; bus.data_sram_addr = 32'h302;
    bus.data_sram_size = 1; bus.data_sram_wstrb = 4'hc; bus.data_sram_wdata = 32'h1234_0000;
    smp(); chk("half_aok", {31'd0, bus.data_sram_addr_ok}, 32'd1);
    data_exp_q.push_back({1'b1, 32'd0});
    step(); bus.data_sram_req = 0; bus.awready = 1; bus.wready = 1;
    smp();
    chk("half_awsize", {29'd0, bus.awsize}, 32'd1);
    chk("half_wstrb", {28'd0, bus.wstrb}, 32'hc);
    step(); bus.awready = 0; bus.wready = 0; bus.bvalid = 1;
    smp(); chk("half_dok", {31'd0, bus.data_sram_data_ok}, 32'd1);
    step(); bus.bvalid = 0;

    // reset in the middle of a pending data read
    bus.data_sram_req = 1; bus.data_sram_wr = 0; bus.data_sram_addr = 32'h300; bus.data_sram_size = 2;
    smp(); chk("mid_aok", {31'd0, bus.data_sram_addr_ok}, 32'd1);
    step(); bus.data_sram_req = 0;
    smp(); chk("mid_arvalid", {31'd0, bus.arvalid}, 32'd1);
    #2 resetn = 1'b0;
    #1 chk("mid_async_clr", {31'd0, bus.arvalid}, 32'd0);
    step();
    step(); resetn = 1'b1;
    bus.inst_sram_req = 1; bus.inst_sram_addr = 32'h1c000010; bus.inst_sram_size = 2;
    bus.data_sram_req = 1; bus.data_sram_wr = 1; bus.data_sram_addr = 32'h400;
    bus.data_sram_size = 2; bus.data_sram_wstrb = 4'hf; bus.data_sram_wdata = 32'h5a5a_5a5a;
    smp();
    chk("post_rst_aok", {30'd0, bus.inst_sram_addr_ok, bus.data_sram_addr_ok}, 32'd3);
    inst_exp_q.push_back(32'hcafe_0001);
    data_exp_q.push_back({1'b1, 32'd0});
    step(); bus.inst_sram_req = 0; bus.data_sram_req = 0;
    bus.arready = 1; bus.awready = 1; bus.wready = 1;
    smp(); chk("post_rst_valids", {29'd0, bus.arvalid, bus.awvalid, bus.wvalid}, 32'd7);
    step(); bus.arready = 0; bus.awready = 0; bus.wready = 0;
    bus.rvalid = 1; bus.rid = 0; bus.rdata = 32'hcafe_0001; bus.bvalid = 1;
    smp();
    step(); bus.rvalid = 0; bus.bvalid = 0;

    smp();
    chk("inst_q_drained", inst_exp_q.size(), 32'd0);
    chk("data_q_drained", data_exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sram_axi_bridge.md
# sram_axi_bridge

Converts the core's two SRAM-like ports (instruction fetch, data access) into a single AXI master and arbitrates the shared read channel between them. Sits between the CPU core and the top-level AXI interface. Tracks at most one outstanding read per port and one outstanding write, and routes every response back to its originating port by ID.

## Interface
Parameters:
- None. ID width is 4, address and data widths are 32.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- inst_sram_req / wr / size / wstrb / addr / wdata  in  1/1/2/4/32/32  fetch request; wr, wstrb, wdata ignored (fetch is read-only)
- inst_sram_addr_ok  out  1  fetch request accepted this cycle
- inst_sram_data_ok  out  1  fetch data valid this cycle
- inst_sram_rdata  out  32  fetch data
- data_sram_req / wr / size / wstrb / addr / wdata  in  1/1/2/4/32/32  load/store request
- data_sram_addr_ok  out  1  data request accepted this cycle
- data_sram_data_ok  out  1  load data valid or store complete
- data_sram_rdata  out  32  load data
- arid  out  4  0 = inst, 1 = data
- araddr  out  32  read address
- arsize  out  3  {1'b0, size}
- arvalid  out  1  read address valid
- arready  in  1  read address ready
- arlen, arburst, arlock, arcache, arprot  out  8/2/2/4/3  constants 0 / 2'b01 / 0 / 0 / 0
- rid  in  4  read response ID
- rdata  in  32  read data
- rresp  in  2  read response (ignored)
- rlast  in  1  last read beat (ignored)
- rvalid  in  1  read data valid
- rready  out  1  constant 1
- awid  out  4  constant 1
- awaddr  out  32  write address
- awsize  out  3  {1'b0, size}
- awvalid  out  1  write address valid
- awready  in  1  write address ready
- awlen, awburst, awlock, awcache, awprot  out  8/2/2/4/3  same constants as AR
- wid  out  4  constant 1
- wdata  out  32  write data
- wstrb  out  4  write strobe
- wlast  out  1  constant 1
- wvalid  out  1  write data valid
- wready  in  1  write data ready
- bid  in  4  write response ID (ignored)
- bresp  in  2  write response (ignored)
- bvalid  in  1  write response valid
- bready  out  1  constant 1

## Operation
State:
- AR holding register: busy while arvalid = 1.
- Pending flags: inst_rd_pend, data_rd_pend.
- Write FSM: W_IDLE -> W_REQ (awvalid/wvalid asserted) -> W_RESP -> W_IDLE.

addr_ok is combinational from registered state only. It does not depend on same-cycle AXI inputs.

- **Data read:** data_sram_addr_ok = !arvalid & !data_rd_pend & W_IDLE. The W_IDLE term blocks read-after-write.
- **Data write:** data_sram_addr_ok = W_IDLE & !data_rd_pend & !(arvalid & arid == 1).
- **Inst read:** inst_sram_addr_ok = !arvalid & !inst_rd_pend & !(data_sram_req & !data_sram_wr & data read eligible). Data reads have priority over fetch.
- **Accepted read (req & addr_ok):**
  - Capture addr and size.
  - Set arid and the matching pend flag.
  - Assert arvalid next cycle.
  - Clear arvalid on arvalid & arready.
- **Accepted write:**
  - Capture addr, size, wstrb, wdata.
  - Enter W_REQ and assert awvalid and wvalid together.
  - Each valid drops independently on its own handshake (AW and W may complete in any order or cycle).
  - Enter W_RESP once both have completed.
- **Read response (rvalid):**
  - rid = 0: inst_sram_data_ok = 1, inst_sram_rdata = rdata, clear inst_rd_pend at the edge.
  - rid = 1: same on the data port, clear data_rd_pend.
- **Write response:** bvalid in W_RESP gives data_sram_data_ok = 1 and returns to W_IDLE at the edge.
- **Response delivery:** the bridge never drops or reorders a response within a port. The core must accept data_ok in any cycle, including responses for flushed requests.
- **Unexpected responses:** rvalid with no matching pend flag, or bvalid outside W_RESP, is a protocol error. No state change; flagged by a bench assertion.

## Timing
- **Reset:** all outputs reset to 0 except the constants: rready = 1, bready = 1, wlast = 1, arburst = awburst = 2'b01, awid = wid = 1. FSM resets to W_IDLE. Reset mid-transaction discards all pending state; the AXI slave is reset concurrently.
- **Read path:** request accepted at cycle T -> arvalid at T+1. If arready is high at T+1, the next read can be accepted at T+2.
- **Read response:** rvalid at cycle R -> data_ok and rdata in the same cycle R (combinational pass-through). A new request on the same port can be accepted from R+1.
- **Write path:**
  - Accepted at T -> awvalid and wvalid at T+1.
  - bvalid at B -> data_ok at B.
  - Next data request accepted from B+1.
- **Shared read channel:** inst and data reads can both be outstanding at once. Their responses may return in either order.

## Test plan
- **Fetch:** inst req addr 0x1c000000 at T, arready = 1 -> arvalid/arid = 0 at T+1 only; rvalid rid = 0 rdata 0x02800404 -> inst_sram_data_ok with that data the same cycle.
- **Arbitration:** inst and data read requested at the same cycle -> data_sram_addr_ok = 1, inst_sram_addr_ok = 0. Inst is accepted once arvalid drops; responses returned out of order (rid 0 first) each reach the correct port.
- **Store split handshake:** store addr 0x100, wdata 0xdeadbeef, wstrb 0xF; awready at T+1, wready at T+3 -> wvalid held until T+3; bvalid -> data_sram_data_ok.
- **Read-after-write block:** load request while in W_RESP -> data_sram_addr_ok = 0 until the cycle after bvalid.
- **Size mapping:** byte load with size 0 -> arsize = 0; halfword store with wstrb 0xC -> awsize = 1 and wstrb = 0xC.
- **Reset mid-transaction:** deassert resetn with arvalid = 1 and data_rd_pend = 1 -> arvalid = 0 immediately (asynchronously); after release, both addr_ok = 1 for fresh requests.
